board_cache_sync: RTL and testbench
===================================

// Module: board_cache_sync
// PURPOSE
//  Requester-side client of the SPI FRAM controller's port handshake (req/grant/addr/data/valid).
//  Sweeps all board cells out of the FRAM into a local 2-bit shadow array after a start pulse.
//  Issues single-cell write-through updates (shadow + FRAM) for the game logic.
//  Game logic then reads board cells combinationally from the shadow, never touching SPI.
// PARAMETERS
//  ADDR_W          6     cell address width
//  DATA_W          2     cell width (00 empty, 01 black, 10 white, 11 reserved)
//  NUM_CELLS       64    cells swept; must be 1..2**ADDR_W
//  TIMEOUT_CYCLES  1024  max cycles in S_REQ before abort (used only with macro)
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous reset, active low
//  start        in   1       pulse: begin full sweep
//  wr_req       in   1       level: request write of wr_data to wr_addr
//  wr_addr      in   ADDR_W  write cell address
//  wr_data      in   DATA_W  write cell value
//  wr_ack       out  1       1-cycle pulse: write completed in FRAM and shadow
//  busy         out  1       high whenever state != S_IDLE
//  done         out  1       1-cycle pulse: sweep finished (also on abort)
//  err          out  1       sticky timeout flag; cleared by next accepted start
//  rd_addr      in   ADDR_W  local lookup address
//  rd_data      out  DATA_W  shadow[rd_addr], combinational
//  mem_req      out  1       request to controller port
//  mem_grant    in   1       grant from controller arbiter
//  mem_we       out  1       1 = write transaction
//  mem_addr     out  ADDR_W  transaction address, stable while mem_req high
//  mem_wr_data  out  DATA_W  write data, stable while mem_req high
//  mem_rd_data  in   DATA_W  read data from controller port
//  mem_valid    in   1       controller completion flag
// BEHAVIOUR
//  Reset: all outputs 0; shadow cleared to 0; state S_IDLE; cell counter 0.
//  States: S_IDLE -> S_REQ -> S_RELEASE -> (S_REQ | S_IDLE).
//  S_IDLE: wr_req has priority: latch wr_addr/wr_data, op=WRITE, go S_REQ.
//   start with op=SWEEP, counter=0; if start coincides with wr_req, start latched pending,
//   sweep begins the cycle after the write's S_RELEASE exits. start while busy: latched pending.
//  S_REQ: mem_req=1, mem_addr/mem_we/mem_wr_data held from latch/counter.
//   On mem_grant && mem_valid (same cycle): READ -> shadow[counter] <= mem_rd_data;
//   WRITE -> shadow[wr_addr] <= wr_data; go S_RELEASE. mem_valid without grant ignored.
//  S_RELEASE: mem_req=0; wait mem_valid==0 (controller restarts if req seen with valid low).
//   Then: WRITE -> wr_ack pulse, S_IDLE. SWEEP and counter==NUM_CELLS-1 -> done pulse,
//   S_IDLE. Else counter+1, S_REQ. Min 3 cycles per cell plus SPI time.
//  Counter is ADDR_W+1 bits; no wrap: NUM_CELLS==2**ADDR_W ends at max address.
//  wr_req sampled only in S_IDLE; requester holds it until wr_ack; wr_req during sweep waits.
//  rd_data during sweep returns old shadow for cells not yet refreshed.
//  Reset mid-transaction: mem_req drops immediately (async); no ack/done emitted.
// CONFIGURATION
//  BOARD_CACHE_SYNC_TIMEOUT_EN defined: counter runs in S_REQ; reaching TIMEOUT_CYCLES drops
//   mem_req, sets err, go S_RELEASE, then S_IDLE. SWEEP abort emits done; WRITE abort emits
//   wr_ack. Shadow not updated. Pending start still honoured.
//  Undefined: no counter; S_REQ waits indefinitely; err tied 0.
// TESTING
//  1 reset, start, model returns cell i = i%3 -> 64 reads, done pulse once, rd_data(10)=01.
//  2 wr_req addr 5 data 10 -> mem_we=1, mem_addr=5, wr_ack 1 pulse, rd_data(5)=10.
//  3 start and wr_req same cycle -> write completes first, then 64-read sweep, one done.
//  4 grant withheld 50 cycles mid-sweep -> mem_req held, addr stable, sweep completes correctly.
//  5 (TIMEOUT_EN, TIMEOUT_CYCLES=16) grant never given -> after 16 cycles err=1, done, req=0.
//  6 rst_n low at cell 30 -> all outputs 0, shadow 0, next start sweeps from cell 0.

Source files
------------

// File: rtl/board_cache_sync.sv
// board_cache_sync: requester-side client of the SPI FRAM controller port.
// Sweeps all board cells from FRAM into a local shadow array on a start pulse and
// performs single-cell write-through updates (shadow + FRAM) for the game logic.
// rd_data is a combinational lookup into the shadow and never touches SPI.
// Optional feature macro: BOARD_CACHE_SYNC_TIMEOUT_EN (S_REQ timeout with abort and err).
module board_cache_sync #(
   parameter int ADDR_W         = 6,
   parameter int DATA_W         = 2,
   parameter int NUM_CELLS      = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              mem_req,
   input  logic              mem_grant,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic              mem_valid
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(NUM_CELLS - 1);

   // Elaboration-time sanity check of the configuration.
   if (NUM_CELLS < 1 || NUM_CELLS > DEPTH || TIMEOUT_CYCLES < 1) begin : gen_bad_cfg
      $error("board_cache_sync: invalid NUM_CELLS or TIMEOUT_CYCLES");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t            state_q;
   logic              op_write_q;   // 1 = single-cell write, 0 = sweep
   logic              pend_q;       // start seen while busy or alongside wr_req
   logic [CNT_W-1:0]  cnt_q;        // sweep cell counter, never wraps
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wr_data_q;
   logic              done_q;
   logic              wr_ack_q;

   logic [DATA_W-1:0] shadow_q [DEPTH];
   logic              shadow_we_d;
   logic [DATA_W-1:0] shadow_wdata_d;

`ifdef BOARD_CACHE_SYNC_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_q;     // cycles spent in the current S_REQ
   logic             abort_q;   // current transaction ended by timeout
   logic             err_q;
`endif

   // Shadow update strobe: completion handshake of the transaction in flight.
   always_comb begin
      shadow_we_d    = (state_q == S_REQ) && mem_grant && mem_valid;
      shadow_wdata_d = op_write_q ? mem_wr_data_q : mem_rd_data;
   end

   // Shadow array: cleared by reset, written on each completed transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            shadow_q[i] <= '0;
         end
      end else if (shadow_we_d) begin
         shadow_q[mem_addr_q] <= shadow_wdata_d;
      end
   end

   // Main sequencer: arbitration between write and sweep, port handshake, pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         op_write_q    <= 1'b0;
         pend_q        <= 1'b0;
         cnt_q         <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wr_data_q <= '0;
         done_q        <= 1'b0;
         wr_ack_q      <= 1'b0;
`ifdef BOARD_CACHE_SYNC_TIMEOUT_EN
         tmo_q         <= '0;
         abort_q       <= 1'b0;
         err_q         <= 1'b0;
`endif
      end else begin
         done_q   <= 1'b0;
         wr_ack_q <= 1'b0;

         // A start arriving mid-operation is remembered and served from S_IDLE.
         if (start && (state_q != S_IDLE)) begin
            pend_q <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (wr_req) begin
                  op_write_q    <= 1'b1;
                  mem_we_q      <= 1'b1;
                  mem_addr_q    <= wr_addr;
                  mem_wr_data_q <= wr_data;
                  mem_req_q     <= 1'b1;
                  state_q       <= S_REQ;
                  if (start) begin
                     pend_q <= 1'b1;
                  end
`ifdef BOARD_CACHE_SYNC_TIMEOUT_EN
                  tmo_q   <= '0;
                  abort_q <= 1'b0;
`endif
               end else if (start || pend_q) begin
                  op_write_q <= 1'b0;
                  mem_we_q   <= 1'b0;
                  cnt_q      <= '0;
                  mem_addr_q <= '0;
                  mem_req_q  <= 1'b1;
                  pend_q     <= 1'b0;
                  state_q    <= S_REQ;
`ifdef BOARD_CACHE_SYNC_TIMEOUT_EN
                  tmo_q   <= '0;
                  abort_q <= 1'b0;
                  err_q   <= 1'b0;
`endif
               end
            end

            S_REQ: begin
               if (mem_grant && mem_valid) begin
                  mem_req_q <= 1'b0;
                  state_q   <= S_RELEASE;
`ifdef BOARD_CACHE_SYNC_TIMEOUT_EN
               end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                  mem_req_q <= 1'b0;
                  abort_q   <= 1'b1;
                  err_q     <= 1'b1;
                  state_q   <= S_RELEASE;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
`endif
               end
            end

            S_RELEASE: begin
               // Controller must drop valid before the next request is raised.
               if (!mem_valid) begin
                  if (op_write_q) begin
                     wr_ack_q <= 1'b1;
                     mem_we_q <= 1'b0;
                     state_q  <= S_IDLE;
`ifdef BOARD_CACHE_SYNC_TIMEOUT_EN
                  end else if (abort_q || (cnt_q == LAST_CELL)) begin
`else
                  end else if (cnt_q == LAST_CELL) begin
`endif
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     cnt_q      <= cnt_q + 1'b1;
                     mem_addr_q <= cnt_q[ADDR_W-1:0] + 1'b1;
                     mem_req_q  <= 1'b1;
                     state_q    <= S_REQ;
`ifdef BOARD_CACHE_SYNC_TIMEOUT_EN
                     tmo_q <= '0;
`endif
                  end
               end
            end

            default: begin
               state_q   <= S_IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign wr_ack      = wr_ack_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wr_data = mem_wr_data_q;
   assign rd_data     = shadow_q[rd_addr];
`ifdef BOARD_CACHE_SYNC_TIMEOUT_EN
   assign err         = err_q;
`else
   assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_board_cache_sync.sv
// Directed testbench for board_cache_sync with a behavioural FRAM controller port.
module tb_board_cache_sync;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       wr_req;
   logic [5:0] wr_addr;
   logic [1:0] wr_data;
   logic       wr_ack;
   logic       busy;
   logic       done;
   logic       err;
   logic [5:0] rd_addr;
   logic [1:0] rd_data;
   logic       mem_req;
   logic       mem_grant;
   logic       mem_we;
   logic [5:0] mem_addr;
   logic [1:0] mem_wr_data;
   logic [1:0] mem_rd_data;
   logic       mem_valid;

`ifdef BOARD_CACHE_SYNC_TIMEOUT_EN
   localparam int HOLD_CYC = 10;
`else
   localparam int HOLD_CYC = 50;
`endif

   board_cache_sync #(
      .ADDR_W(6), .DATA_W(2), .NUM_CELLS(64), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .wr_req(wr_req),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy),
      .done(done), .err(err), .rd_addr(rd_addr), .rd_data(rd_data),
      .mem_req(mem_req), .mem_grant(mem_grant), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data), .mem_valid(mem_valid)
   );

   always #5 clk = ~clk;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   // test-owned controls
   bit hold    = 1'b0;
   int pat_off = 0;
   int pat_gen = 1;

   // model-owned state
   logic [1:0] fram [64];
   int         seen_gen = 0;
   int         lat      = 0;
   bit         txn_we   [$];
   int         txn_addr [$];
   int         done_cnt = 0;
   int         ack_cnt  = 0;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Controller model: grant+valid together two cycles after req, valid held until req drops.
   always @(negedge clk) begin
      if (seen_gen != pat_gen) begin
         for (int i = 0; i < 64; i++) fram[i] = 2'((i + pat_off) % 3);
         seen_gen = pat_gen;
      end
      if (!rst_n) begin
         mem_grant = 1'b0;
         mem_valid = 1'b0;
         lat       = 0;
      end else if (mem_valid) begin
         if (!mem_req) begin
            mem_grant = 1'b0;
            mem_valid = 1'b0;
         end
      end else if (mem_req && !hold) begin
         if (lat == 2) begin
            lat       = 0;
            mem_grant = 1'b1;
            mem_valid = 1'b1;
            txn_we.push_back(mem_we);
            txn_addr.push_back(int'(mem_addr));
            if (mem_we) begin
               fram[mem_addr] = mem_wr_data;
               mem_rd_data    = 2'b00;
            end else begin
               mem_rd_data = fram[mem_addr];
            end
         end else begin
            lat++;
         end
      end
   end

   // Pulse monitor.
   always @(negedge clk) begin
      if (done)   done_cnt++;
      if (wr_ack) ack_cnt++;
   end

   function automatic int reads_since(input int base);
      int n = 0;
      for (int i = base; i < txn_we.size(); i++) if (!txn_we[i]) n++;
      return n;
   endfunction

   task automatic chk_rd(input string tag, input logic [5:0] a, input logic [1:0] exp);
      rd_addr = a;
      #1;
      check_vec(tag, rd_data, exp);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int limit);
      bit seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (done) begin seen = 1'b1; break; end
      end
      check_vec(tag, seen, 1'b1);
   endtask

   task automatic wait_ack(input string tag, input int limit);
      bit seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (wr_ack) begin seen = 1'b1; break; end
      end
      wr_req = 1'b0;
      check_vec(tag, seen, 1'b1);
   endtask

   task automatic do_write(input string tag, input logic [5:0] a, input logic [1:0] d);
      bit seen = 1'b0;
      @(negedge clk);
      wr_req = 1'b1; wr_addr = a; wr_data = d;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_req) begin seen = 1'b1; break; end
      end
      check_vec({tag, "_req"}, seen, 1'b1);
      check_vec({tag, "_we"}, mem_we, 1'b1);
      check_vec({tag, "_addr"}, mem_addr, a);
      check_vec({tag, "_wdata"}, mem_wr_data, d);
      wait_ack({tag, "_ack"}, 50);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int b, d0, a0, a1, bad;
      rst_n = 1'b0; start = 1'b0; wr_req = 1'b0;
      wr_addr = '0; wr_data = '0; rd_addr = '0;
      mem_grant = 1'b0; mem_valid = 1'b0; mem_rd_data = '0;
      repeat (3) @(negedge clk);

      // 1: reset state, full sweep with cell i = i%3
      check_vec("rst_busy", busy, 1'b0);
      check_vec("rst_done", done, 1'b0);
      check_vec("rst_ack", wr_ack, 1'b0);
      check_vec("rst_err", err, 1'b0);
      check_vec("rst_req", mem_req, 1'b0);
      check_vec("rst_we", mem_we, 1'b0);
      check_vec("rst_addr", mem_addr, 6'd0);
      chk_rd("rst_rd10", 6'd10, 2'b00);
      rst_n = 1'b1;
      b = txn_we.size(); d0 = done_cnt;
      pulse_start();
      check_vec("t1_busy", busy, 1'b1);
      wait_done("t1_done", 2000);
      repeat (4) @(negedge clk);
      check_vec("t1_reads", reads_since(b), 64);
      check_vec("t1_done_cnt", done_cnt - d0, 1);
      check_vec("t1_idle", busy, 1'b0);
      check_vec("t1_err", err, 1'b0);
      chk_rd("t1_rd10", 6'd10, 2'b01);
      chk_rd("t1_rd2", 6'd2, 2'b10);
      chk_rd("t1_rd63", 6'd63, 2'b00);
      $display("txn sweep1 reads=%0d", reads_since(b));

      // 2: write-through updates
      b = txn_we.size(); d0 = ack_cnt;
      do_write("t2a", 6'd5, 2'b10);
      do_write("t2b", 6'd10, 2'b11);
      repeat (4) @(negedge clk);
      check_vec("t2_ack_cnt", ack_cnt - d0, 2);
      check_vec("t2_txns", txn_we.size() - b, 2);
      check_vec("t2_fram10", fram[10], 2'b11);
      chk_rd("t2_rd5", 6'd5, 2'b10);
      chk_rd("t2_rd10", 6'd10, 2'b11);
      chk_rd("t2_rd11", 6'd11, 2'b10);
      $display("txn writes acks=%0d", ack_cnt - d0);

      // 3: start and wr_req together: write first, then a full sweep
      b = txn_we.size(); d0 = done_cnt; a0 = ack_cnt;
      @(negedge clk);
      start = 1'b1; wr_req = 1'b1; wr_addr = 6'd10; wr_data = 2'b10;
      @(negedge clk);
      start = 1'b0;
      wait_ack("t3_ack", 50);
      wait_done("t3_done", 2000);
      repeat (4) @(negedge clk);
      a1 = (txn_we.size() > b) ? int'(txn_we[b]) : -1;
      check_vec("t3_first_is_wr", a1, 1);
      a1 = (txn_addr.size() > b + 1) ? txn_addr[b + 1] : -1;
      check_vec("t3_sweep_addr0", a1, 0);
      check_vec("t3_reads", reads_since(b), 64);
      check_vec("t3_done_cnt", done_cnt - d0, 1);
      check_vec("t3_ack_cnt", ack_cnt - a0, 1);
      chk_rd("t3_rd10", 6'd10, 2'b10);
      chk_rd("t3_rd12", 6'd12, 2'b00);
      $display("txn write+sweep reads=%0d", reads_since(b));

      // 4: grant withheld mid-sweep with new FRAM content (i+1)%3
      pat_off = 1; pat_gen = pat_gen + 1;
      @(negedge clk);
      b = txn_we.size(); d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 1000; i++) begin
         if (reads_since(b) >= 20) break;
         @(negedge clk);
      end
      hold = 1'b1;
      a1 = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_req) begin a1 = 1; break; end
      end
      check_vec("t4_req_up", a1, 1);
      a0 = int'(mem_addr);
      check_vec("t4_hold_addr", a0, 20);
      bad = 0;
      for (int i = 0; i < HOLD_CYC; i++) begin
         @(negedge clk);
         if (!mem_req || int'(mem_addr) != a0) bad++;
      end
      check_vec("t4_stable", bad, 0);
      hold = 1'b0;
      wait_done("t4_done", 2000);
      repeat (4) @(negedge clk);
      check_vec("t4_reads", reads_since(b), 64);
      check_vec("t4_done_cnt", done_cnt - d0, 1);
      chk_rd("t4_rd20", 6'd20, 2'b00);
      chk_rd("t4_rd10", 6'd10, 2'b10);
      chk_rd("t4_rd63", 6'd63, 2'b01);
      $display("txn held sweep reads=%0d", reads_since(b));

      // 6: reset at cell 30, then a clean sweep from cell 0
      pat_off = 0; pat_gen = pat_gen + 1;
      @(negedge clk);
      b = txn_we.size();
      pulse_start();
      for (int i = 0; i < 1000; i++) begin
         if (reads_since(b) >= 30) break;
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      check_vec("t6_req", mem_req, 1'b0);
      check_vec("t6_busy", busy, 1'b0);
      check_vec("t6_done", done, 1'b0);
      check_vec("t6_ack", wr_ack, 1'b0);
      chk_rd("t6_rd1", 6'd1, 2'b00);
      chk_rd("t6_rd63", 6'd63, 2'b00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      b = txn_we.size(); d0 = done_cnt;
      pulse_start();
      wait_done("t6_done2", 2000);
      repeat (4) @(negedge clk);
      a1 = (txn_addr.size() > b) ? txn_addr[b] : -1;
      check_vec("t6_first_addr", a1, 0);
      check_vec("t6_reads", reads_since(b), 64);
      check_vec("t6_done_cnt", done_cnt - d0, 1);
      chk_rd("t6_rd10", 6'd10, 2'b01);
      $display("txn reset+sweep reads=%0d", reads_since(b));

`ifdef BOARD_CACHE_SYNC_TIMEOUT_EN
      // 5: grant never given -> abort after 16 cycles in S_REQ
      hold = 1'b1;
      b = txn_we.size(); d0 = done_cnt;
      pulse_start();
      wait_done("t5_done", 200);
      check_vec("t5_err", err, 1'b1);
      check_vec("t5_req", mem_req, 1'b0);
      repeat (4) @(negedge clk);
      check_vec("t5_busy", busy, 1'b0);
      check_vec("t5_done_cnt", done_cnt - d0, 1);
      check_vec("t5_no_txn", txn_we.size() - b, 0);
      chk_rd("t5_rd10", 6'd10, 2'b01);
      hold = 1'b0;
      $display("txn timeout err=%0d", err);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
